// File: rtl/regfile_led_scanner_if.sv
//------------------------------------------------------------------------------
// Module      : regfile_led_scanner_if
// Description : Bundles the register file read port, control inputs and LED outputs of the scanner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_led_scanner_if #(
  parameter int AW = 5
);
  logic          start;
  logic          abort;
  logic          mode;
  logic          step;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;
  logic [7:0]    led;
  logic [1:0]    byte_sel;
  logic          busy;
  logic          done;

  modport master (
    input  start, abort, mode, step, start_addr, end_addr, r_data,
    output r_addr, led, byte_sel, busy, done
  );

  modport slave (
    output start, abort, mode, step, start_addr, end_addr, r_data,
    input  r_addr, led, byte_sel, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/regfile_led_scanner.sv
//------------------------------------------------------------------------------
// Module      : regfile_led_scanner
// Description : Walks a register file address range and shows each word a byte at a time on the LEDs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_led_scanner #(
  parameter int DWELL = 4,
  parameter int AW    = 5
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  regfile_led_scanner_if.master   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SHOW  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int            CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DWELL - 1);

  logic [2:0]    state_q,    state_d;
  logic [AW-1:0] r_addr_q,   r_addr_d;
  logic [31:0]   latch_q,    latch_d;
  logic [7:0]    led_q,      led_d;
  logic [1:0]    byte_sel_q, byte_sel_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          step_q,     step_d;

  logic          w_adv;
  logic [1:0]    w_sel_inc;
  logic [7:0]    w_next_byte;
  logic          busy_o;
  logic          done_o;

  // Manual advance fires once per button press; auto advance on the last dwell cycle.
  assign w_adv       = bus.mode ? (bus.step & ~step_q) : (cnt_q == C_CNT_LAST);
  assign w_sel_inc   = byte_sel_q + 2'd1;
  assign w_next_byte = latch_q[{w_sel_inc, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r_addr_q   <= '0;
      latch_q    <= '0;
      led_q      <= '0;
      byte_sel_q <= '0;
      cnt_q      <= '0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_addr_q   <= r_addr_d;
      latch_q    <= latch_d;
      led_q      <= led_d;
      byte_sel_q <= byte_sel_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    r_addr_d   = r_addr_q;
    latch_d    = latch_q;
    led_d      = led_q;
    byte_sel_d = byte_sel_q;
    cnt_d      = cnt_q;
    step_d     = bus.step;

    if (bus.abort) begin
      state_d    = S_IDLE;
      led_d      = '0;
      byte_sel_d = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_addr_d = bus.start_addr;
            state_d  = S_FETCH;
          end
        end
        S_FETCH: begin
          latch_d    = bus.r_data;
          led_d      = bus.r_data[7:0];
          byte_sel_d = '0;
          cnt_d      = '0;
          state_d    = S_SHOW;
        end
        S_SHOW: begin
          // Holding the counter at zero in manual mode makes a switch to auto start a fresh dwell.
          if (bus.mode || (cnt_q == C_CNT_LAST)) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          if (w_adv) begin
            if (byte_sel_q == 2'd3) begin
              state_d = S_NEXT;
            end else begin
              byte_sel_d = w_sel_inc;
              led_d      = w_next_byte;
            end
          end
        end
        S_NEXT: begin
          if (r_addr_q == bus.end_addr) begin
            state_d = S_DONE;
          end else begin
            r_addr_d = r_addr_q + AW'(1);
            state_d  = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_FETCH, S_SHOW, S_NEXT: busy_o = 1'b1;
      S_DONE:                  done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  assign bus.r_addr   = r_addr_q;
  assign bus.led      = led_q;
  assign bus.byte_sel = byte_sel_q;
  assign bus.busy     = busy_o;
  assign bus.done     = done_o;

endmodule

`default_nettype wire

// File: tb/tb_regfile_led_scanner.sv
//------------------------------------------------------------------------------
// Module      : tb_regfile_led_scanner
// Description : Directed self-checking bench for the register file LED scanner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_led_scanner;

  localparam int AW    = 5;
  localparam int DWELL = 4;

  logic clk;
  logic rst_n;
  logic [31:0] regs [0:31];

  int n_checks;
  int n_pass;

  regfile_led_scanner_if #(.AW(AW)) bus ();

  regfile_led_scanner #(.DWELL(DWELL), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.r_data = regs[bus.r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock edge, then settle 1 ns past it before checking or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
    return w[idx*8 +: 8];
  endfunction

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  exp_led;
    logic        bad_addr;
    logic        seen31;
    logic        seen0;
    int          n;

    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[0]  = 32'h0000_000F;
    regs[1]  = 32'h0000_0DB0;
    regs[3]  = 32'hFFFF_FFFF;
    regs[31] = 32'h1122_3344;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.mode       = 1'b0;
    bus.step       = 1'b0;
    bus.start_addr = '0;
    bus.end_addr   = '0;

    #3;
    check("rst_led",    {24'h0, bus.led},      32'h0);
    check("rst_raddr",  {27'h0, bus.r_addr},   32'h0);
    check("rst_bsel",   {30'h0, bus.byte_sel}, 32'h0);
    check("rst_busy",   {31'h0, bus.busy},     32'h0);
    check("rst_done",   {31'h0, bus.done},     32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Auto scan of [0..1]: 4 cycles per byte, byte 0 two cycles after Start.
    w0 = regs[0];
    w1 = regs[1];
    bus.start_addr = 5'd0;
    bus.end_addr   = 5'd1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check("a_fetch_busy", {31'h0, bus.busy}, 32'h1);
    for (int c = 2; c <= 37; c++) begin
      tick();
      if (c <= 17)      exp_led = byte_of(w0, (c - 2) / 4);
      else if (c <= 19) exp_led = byte_of(w0, 3);
      else if (c <= 35) exp_led = byte_of(w1, (c - 20) / 4);
      else              exp_led = byte_of(w1, 3);
      check($sformatf("a_led_c%0d", c), {24'h0, bus.led}, {24'h0, exp_led});
      if (c == 36) check("a_busy_next", {31'h0, bus.busy}, 32'h1);
    end
    check("a_done", {31'h0, bus.done}, 32'h1);
    check("a_busy_end", {31'h0, bus.busy}, 32'h0);
    check("a_raddr_end", {27'h0, bus.r_addr}, 32'd1);

    // Manual single-register scan of [3].
    bus.mode       = 1'b1;
    bus.start_addr = 5'd3;
    bus.end_addr   = 5'd3;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check("m_done_clr", {31'h0, bus.done}, 32'h0);
    tick();
    check("m_led0", {24'h0, bus.led}, 32'hFF);
    check("m_bsel0", {30'h0, bus.byte_sel}, 32'd0);
    bus.step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.step = 1'b0;
    tick();
    check("m_bsel_held", {30'h0, bus.byte_sel}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      tick();
    end
    check("m_done", {31'h0, bus.done}, 32'h1);
    check("m_busy", {31'h0, bus.busy}, 32'h0);
    check("m_led_hold", {24'h0, bus.led}, 32'hFF);
    check("m_bsel_hold", {30'h0, bus.byte_sel}, 32'd3);

    // Restart from DONE with [1]; then Start ignored while busy, then Abort.
    bus.mode       = 1'b0;
    bus.start_addr = 5'd1;
    bus.end_addr   = 5'd1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check("r_done_clr", {31'h0, bus.done}, 32'h0);
    check("r_busy", {31'h0, bus.busy}, 32'h1);
    check("r_raddr", {27'h0, bus.r_addr}, 32'd1);
    tick();
    check("r_led_b0", {24'h0, bus.led}, 32'hB0);
    bus.start_addr = 5'd3;
    bus.start      = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    check("s_ign_raddr", {27'h0, bus.r_addr}, 32'd1);
    check("s_ign_busy", {31'h0, bus.busy}, 32'h1);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_busy", {31'h0, bus.busy}, 32'h0);
    check("ab_done", {31'h0, bus.done}, 32'h0);
    check("ab_led", {24'h0, bus.led}, 32'h0);
    check("ab_bsel", {30'h0, bus.byte_sel}, 32'd0);
    check("ab_raddr", {27'h0, bus.r_addr}, 32'd1);
    tick();
    check("ab_idle", {31'h0, bus.busy}, 32'h0);

    // Wrap scan 31 -> 0; no other address may appear.
    bus.start_addr = 5'd31;
    bus.end_addr   = 5'd0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    bad_addr = 1'b0;
    seen31   = 1'b0;
    seen0    = 1'b0;
    n        = 1;
    while (!bus.done && n < 100) begin
      if (bus.r_addr == 5'd31) seen31 = 1'b1;
      else if (bus.r_addr == 5'd0) seen0 = 1'b1;
      else bad_addr = 1'b1;
      tick();
      n++;
      if (n == 2) check("w_led_first", {24'h0, bus.led}, 32'h44);
    end
    check("w_done", {31'h0, bus.done}, 32'h1);
    check("w_cycles", n, 32'd37);
    check("w_seen31", {31'h0, seen31}, 32'h1);
    check("w_seen0", {31'h0, seen0}, 32'h1);
    check("w_no_other", {31'h0, bad_addr}, 32'h0);

    // Asynchronous reset in the middle of SHOW.
    bus.start_addr = 5'd0;
    bus.end_addr   = 5'd1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("ar_pre_led", {24'h0, bus.led}, 32'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_led", {24'h0, bus.led}, 32'h0);
    check("ar_raddr", {27'h0, bus.r_addr}, 32'h0);
    check("ar_busy", {31'h0, bus.busy}, 32'h0);
    check("ar_done", {31'h0, bus.done}, 32'h0);
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("ar_idle_busy", {31'h0, bus.busy}, 32'h0);
    check("ar_idle_led", {24'h0, bus.led}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
